async_fifo_wr_arbiter: RTL

- Shares the single write port of an async FIFO among NUM_REQ requesters, running in the FIFO write clock domain.
- Uses round-robin arbitration with burst lock: a granted requester keeps the port until it sends req_last, reaches MAX_BURST words, or goes idle past a timeout.
- Drives wrreq/wrdata into the FIFO write side.
- Uses wrfull, prog_full and wrusedw from the FIFO for admission control and flow control.

---
 rtl/async_fifo_wr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst-locked arbiter for an async FIFO write port
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 8,
    parameter int MAX_BURST       = 16,
    parameter int IDLE_TIMEOUT    = 8
) (
    input  logic                          wrclk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wrfull,
    input  logic                          prog_full,
    input  logic [FIFO_ADDR_WIDTH-1:0]    wrusedw,
    output logic                          wrreq,
    output logic [DATA_WIDTH-1:0]         wrdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int FW = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            busy_q, busy_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

    logic [FW-1:0]   free_words;
    logic            admit_ok;
    logic            found;
    logic [GW-1:0]   winner;
    int              idx;
    logic            sel_valid, sel_last, can_write, accept;
    logic [DATA_WIDTH-1:0] sel_data;

    // Headroom check against a full burst keeps overflow impossible even if prog_full lags.
    assign free_words = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}} - {1'b0, wrusedw};
    assign admit_ok   = ~prog_full & ~wrfull & (free_words >= FW'(MAX_BURST));

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    assign sel_valid = req_valid[grant_id_q];
    assign sel_last  = req_last[grant_id_q];
    assign sel_data  = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    assign can_write = ~wrfull & ~prog_full;
    assign accept    = (state_q == S_XFER) & sel_valid & can_write;

    always_comb begin
        req_ready = '0;
        if (state_q == S_XFER) begin
            req_ready[grant_id_q] = can_write;
        end
    end

    assign wrreq    = accept;
    assign wrdata   = (state_q == S_XFER) ? sel_data : '0;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        burst_cnt_d  = burst_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found && admit_ok) begin
                    state_d      = S_XFER;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    busy_d       = 1'b1;
                    burst_cnt_d  = '0;
                    idle_cnt_d   = '0;
                end
            end
            S_XFER: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    idle_cnt_d  = '0;
                    if (sel_last || (burst_cnt_q == BW'(MAX_BURST - 1))) begin
                        state_d = S_RELEASE;
                        busy_d  = 1'b0;
                    end
                end else if (!sel_valid) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                    if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
                        state_d = S_RELEASE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wrclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            busy_q       <= 1'b0;
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end
endmodule
